// File: rtl/prf_wr_arb_pkg.sv
// Shared types, default sizes and small vector helpers for the PRF write arbiter.
package prf_wr_arb_pkg;

   localparam int unsigned PRF_WR_ARB_NUM_REQ = 3;
   localparam int unsigned PRF_WR_ARB_QDEPTH  = 2;

   localparam int unsigned PRF_IDX_W  = 7;
   localparam int unsigned PRF_DATA_W = 32;

   // Widest request vector the rotate/find helpers handle.
   localparam int unsigned FF_VEC_W = 32;
   localparam int unsigned FF_SEL_W = $clog2(FF_VEC_W);

   typedef enum logic [1:0] {
      PTYPE_INT  = 2'd0,
      PTYPE_FP   = 2'd1,
      PTYPE_VEC  = 2'd2,
      PTYPE_FLAG = 2'd3
   } t_ptype;

   typedef struct packed {
      t_ptype               ptype;
      logic [PRF_IDX_W-1:0] idx;
   } t_prf_id;

   typedef struct packed {
      t_prf_id               pdst;
      logic [PRF_DATA_W-1:0] data;
   } t_prf_wr_pkt;

   // Rotate right within the low n bits: result[i] = vec[(i + amt) mod n].
   function automatic logic [FF_VEC_W-1:0] rotate_right(input logic [FF_VEC_W-1:0] vec,
                                                        input int unsigned         amt,
                                                        input int unsigned         n);
      logic [FF_VEC_W-1:0] res;
      logic [FF_SEL_W-1:0] sel;
      res = '0;
      for (int unsigned i = 0; i < FF_VEC_W; i++) begin
         if (i < n) begin
            sel    = FF_SEL_W'((i + amt) % n);
            res[i] = vec[sel];
         end
      end
      return res;
   endfunction

   // Index of the lowest set bit, or FF_VEC_W when the vector is zero.
   function automatic int find_first1(input logic [FF_VEC_W-1:0] vec);
      int pos;
      pos = int'(FF_VEC_W);
      for (int i = int'(FF_VEC_W) - 1; i >= 0; i--) begin
         if (vec[i]) pos = i;
      end
      return pos;
   endfunction

endpackage

// File: rtl/prf_wr_arb_if.sv
// Writeback-side handshake and PRF write-port bundle for prf_wr_arb.
interface prf_wr_arb_if
   import prf_wr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = PRF_WR_ARB_NUM_REQ,
   parameter int unsigned NUM_WR_PORTS = 1
);

   logic [NUM_REQ-1:0]                   req_vld;
   t_prf_wr_pkt [NUM_REQ-1:0]            req_pkt;
   logic [NUM_REQ-1:0]                   req_rdy;
   logic [NUM_WR_PORTS-1:0]              wr_en_nq_ro0;
   t_prf_wr_pkt [NUM_WR_PORTS-1:0]       wr_pkt_ro0;
   logic                                 busy;

   // Producer / PRF side.
   modport master (
      output req_vld, req_pkt,
      input  req_rdy, wr_en_nq_ro0, wr_pkt_ro0, busy
   );

   // Arbiter side.
   modport slave (
      input  req_vld, req_pkt,
      output req_rdy, wr_en_nq_ro0, wr_pkt_ro0, busy
   );

endinterface

// File: rtl/prf_wr_skid_q.sv
// Per-requester skid FIFO of PRF write packets (circular buffer).
module prf_wr_skid_q
   import prf_wr_arb_pkg::*;
#(
   parameter int unsigned QDEPTH = PRF_WR_ARB_QDEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  t_prf_wr_pkt push_pkt,
   input  logic        pop,
   output logic        head_vld,
   output t_prf_wr_pkt head_pkt,
   output logic        full
);

   localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
   localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   t_prf_wr_pkt      mem [QDEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Pointer and occupancy update; push and pop in one cycle leave count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage is not reset; only slots below count are ever observed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_pkt;
   end

   // Head and status decode from flopped state only.
   always_comb begin
      head_vld = (count != '0);
      head_pkt = mem[rd_ptr];
      full     = (count == CNT_W'(QDEPTH));
   end

`ifndef SYNTHESIS
   // Overflow and underflow are excluded by the handshake and the arbiter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_no_push_full : assert (!(push && full));
         a_no_pop_empty : assert (!(pop && !head_vld));
      end
   end
`endif

endmodule

// File: rtl/prf_wr_arb.sv
// Round-robin arbiter sharing PRF write ports among writeback producers.
module prf_wr_arb
   import prf_wr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = PRF_WR_ARB_NUM_REQ,
   parameter int unsigned NUM_WR_PORTS = 1,
   parameter int unsigned QDEPTH       = PRF_WR_ARB_QDEPTH
) (
   input logic         clk,
   input logic         reset,
   prf_wr_arb_if.slave bus
);

   localparam int unsigned PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned STARVE_BOUND = (NUM_REQ + NUM_WR_PORTS - 1) / NUM_WR_PORTS;

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_ptr_nxt;
   logic [NUM_REQ-1:0] head_vld;
   logic [NUM_REQ-1:0] full;
   logic [NUM_REQ-1:0] rdy;
   logic [NUM_REQ-1:0] push;
   logic [NUM_REQ-1:0] grant;
   t_prf_wr_pkt        head_pkt [NUM_REQ];

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_q
      prf_wr_skid_q #(
         .QDEPTH(QDEPTH)
      ) u_q (
         .clk     (clk),
         .reset   (reset),
         .push    (push[r]),
         .push_pkt(bus.req_pkt[r]),
         .pop     (grant[r]),
         .head_vld(head_vld[r]),
         .head_pkt(head_pkt[r]),
         .full    (full[r])
      );
   end

   // Ready comes only from flopped fullness, so a full queue popping this cycle still stalls.
   always_comb begin
      rdy         = ~full & {NUM_REQ{~reset}};
      push        = bus.req_vld & rdy;
      bus.req_rdy = rdy;
      bus.busy    = (|head_vld) & ~reset;
   end

   // Grant the first NUM_WR_PORTS non-empty queues scanning upward from rr_ptr.
   always_comb begin
      logic [FF_VEC_W-1:0] rot;
      logic [PTR_W-1:0]    gidx;
      int                  first;
      int                  idx;
      grant            = '0;
      bus.wr_en_nq_ro0 = '0;
      bus.wr_pkt_ro0   = '0;
      rr_ptr_nxt       = rr_ptr;
      gidx             = '0;
      first            = 0;
      idx              = 0;
      rot              = rotate_right(FF_VEC_W'(head_vld), int'(rr_ptr), NUM_REQ);
      for (int k = 0; k < int'(NUM_WR_PORTS); k++) begin
         first = find_first1(rot);
         if (!reset && (first < int'(NUM_REQ))) begin
            rot[FF_SEL_W'(first)] = 1'b0;
            idx = first + int'(rr_ptr);
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            gidx                = PTR_W'(idx);
            grant[gidx]         = 1'b1;
            bus.wr_en_nq_ro0[k] = 1'b1;
            bus.wr_pkt_ro0[k]   = head_pkt[gidx];
            // Last grant wins: pointer moves just past it.
            rr_ptr_nxt = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
         end
      end
   end

   // Round-robin pointer; holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (reset) rr_ptr <= '0;
      else       rr_ptr <= rr_ptr_nxt;
   end

`ifndef SYNTHESIS
   logic [7:0] wait_cnt [NUM_REQ];

   // Consecutive cycles each non-empty head has been passed over.
   always_ff @(posedge clk) begin
      for (int r = 0; r < int'(NUM_REQ); r++) begin
         if (reset || !head_vld[r] || grant[r]) wait_cnt[r] <= '0;
         else                                   wait_cnt[r] <= wait_cnt[r] + 8'd1;
      end
   end

   // Port targets are distinct and no head waits past the round-robin bound.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_WR_PORTS); i++) begin
            for (int j = i + 1; j < int'(NUM_WR_PORTS); j++) begin
               a_distinct_pdst : assert (!(bus.wr_en_nq_ro0[i] && bus.wr_en_nq_ro0[j] &&
                                           bus.wr_pkt_ro0[i].pdst == bus.wr_pkt_ro0[j].pdst));
            end
         end
         for (int r = 0; r < int'(NUM_REQ); r++) begin
            a_starve : assert (!(head_vld[r] && !grant[r] &&
                                 wait_cnt[r] >= 8'(STARVE_BOUND - 1)));
         end
      end
   end
`endif

endmodule

// File: tb/tb_prf_wr_arb.sv
// Randomised scoreboard bench for prf_wr_arb against a queue-level reference model.
`timescale 1ns/1ps
module tb_prf_wr_arb;
   import prf_wr_arb_pkg::*;

   localparam int NREQ  = 3;
   localparam int NPORT = 1;
   localparam int QD    = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   prf_wr_arb_if #(.NUM_REQ(NREQ), .NUM_WR_PORTS(NPORT)) bus ();

   prf_wr_arb #(
      .NUM_REQ     (NREQ),
      .NUM_WR_PORTS(NPORT),
      .QDEPTH      (QD)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          port;
      t_prf_wr_pkt pkt;
   } t_exp;

   t_exp          exp_q[$];
   t_prf_wr_pkt   mq[NREQ][$];
   int            rr_m    = 0;
   int            cyc     = 0;
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [NREQ-1:0] drv_vld;
   t_prf_wr_pkt   drv_pkt [NREQ];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, req);
      end
   endtask

   function automatic t_prf_wr_pkt mk(input int pt, input int idx, input logic [31:0] data);
      t_prf_wr_pkt p;
      p.pdst.ptype = t_ptype'(2'(pt));
      p.pdst.idx   = 7'(idx);
      p.data       = data;
      return p;
   endfunction

   // Monitor: every cycle, each port must match the scoreboard entry tagged for that cycle.
   always @(negedge clk) begin
      if (cyc > 0) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_write cyc=%0d: got nothing, expected %h from cyc %0d",
                     cyc, exp_q[0].pkt, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         for (int p = 0; p < NPORT; p++) begin
            logic        e_en;
            t_prf_wr_pkt e_pkt;
            e_en  = 1'b0;
            e_pkt = '0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].port == p) begin
               e_en  = 1'b1;
               e_pkt = exp_q[0].pkt;
               void'(exp_q.pop_front());
            end
            check("wr_en", 64'(bus.wr_en_nq_ro0[p]), 64'(e_en));
            check("wr_pkt", 64'(bus.wr_pkt_ro0[p]), 64'(e_pkt));
         end
      end
   end

   // One cycle: drive inputs, check ready/busy/pointer, advance the reference model.
   task automatic step(input logic rst);
      logic [NREQ-1:0] e_rdy;
      logic            e_busy;
      int              ng;
      int              last;
      t_exp            e;
      @(posedge clk);
      #1;
      cyc++;
      reset       = rst;
      bus.req_vld = drv_vld;
      for (int r = 0; r < NREQ; r++) bus.req_pkt[r] = drv_pkt[r];
      #1;
      e_busy = 1'b0;
      for (int r = 0; r < NREQ; r++) begin
         e_rdy[r] = !rst && (mq[r].size() < QD);
         if (mq[r].size() > 0 && !rst) e_busy = 1'b1;
      end
      check("req_rdy", 64'(bus.req_rdy), 64'(e_rdy));
      check("busy", 64'(bus.busy), 64'(e_busy));
      if (!rst) check("rr_ptr", 64'(dut.rr_ptr), 64'(rr_m));
      if (rst) begin
         for (int r = 0; r < NREQ; r++) mq[r].delete();
         rr_m = 0;
      end else begin
         ng   = 0;
         last = -1;
         for (int k = 0; k < NREQ; k++) begin
            int r;
            r = (rr_m + k) % NREQ;
            if (mq[r].size() > 0 && ng < NPORT) begin
               e.cyc  = cyc;
               e.port = ng;
               e.pkt  = mq[r].pop_front();
               exp_q.push_back(e);
               ng++;
               last = r;
            end
         end
         for (int r = 0; r < NREQ; r++) begin
            if (drv_vld[r] && e_rdy[r]) mq[r].push_back(drv_pkt[r]);
         end
         if (last >= 0) rr_m = (last + 1) % NREQ;
      end
   endtask

   task automatic idle(input int n);
      drv_vld = '0;
      repeat (n) step(1'b0);
   endtask

   initial begin
      int unsigned tag;
      tag     = 0;
      drv_vld = '0;
      for (int r = 0; r < NREQ; r++) drv_pkt[r] = '0;
      bus.req_vld = '0;
      bus.req_pkt = '0;

      // Reset for 3 cycles, then one idle cycle.
      repeat (3) step(1'b1);
      idle(1);

      // Single write from requester 1.
      drv_vld    = 3'b010;
      drv_pkt[1] = mk(0, 5, 32'hDEAD_BEEF);
      step(1'b0);
      idle(3);

      // Three-way contention from rr_ptr = 0.
      step(1'b1);
      drv_vld = 3'b111;
      for (int r = 0; r < NREQ; r++) drv_pkt[r] = mk(r, 10 + r, 32'h1000_0000 + r);
      step(1'b0);
      idle(5);

      // Backpressure: everyone pushes every cycle.
      for (int c = 0; c < 12; c++) begin
         drv_vld = 3'b111;
         for (int r = 0; r < NREQ; r++) begin
            tag++;
            drv_pkt[r] = mk(r, (c * 3 + r) % 128, 32'hB000_0000 + tag);
         end
         step(1'b0);
      end
      idle(8);

      // Reset with packets still queued.
      drv_vld = 3'b011;
      drv_pkt[0] = mk(1, 20, 32'hAAAA_0001);
      drv_pkt[1] = mk(1, 21, 32'hAAAA_0002);
      step(1'b0);
      drv_pkt[0] = mk(1, 22, 32'hAAAA_0003);
      drv_pkt[1] = mk(1, 23, 32'hAAAA_0004);
      step(1'b0);
      drv_vld = '0;
      step(1'b1);
      step(1'b1);
      drv_vld    = 3'b100;
      drv_pkt[2] = mk(2, 99, 32'hC0FF_EE00);
      step(1'b0);
      idle(3);

      // Random traffic with occasional resets.
      for (int c = 0; c < 1500; c++) begin
         logic rst;
         drv_vld = 3'($urandom);
         for (int r = 0; r < NREQ; r++) begin
            drv_pkt[r] = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 127)), $urandom);
         end
         rst = ($urandom_range(0, 99) == 0);
         step(rst);
      end
      idle(10);

      @(negedge clk);
      #1;
      check("exp_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
